// File: rtl/irq_pending_ctrl.sv
// rtl/irq_pending_ctrl.sv - rising-edge interrupt capture with mask, nested in-service tracking and priority request
module irq_pending_ctrl #(
    parameter logic [31:0] VEC_BASE = 32'h0000_0100
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [6:0]  i_irq_in,
    input  logic [6:0]  i_mask_in,
    input  logic        i_irq_ack,
    input  logic        i_eret,
    output logic [6:0]  o_pending,
    output logic [6:0]  o_in_service,
    output logic        o_req,
    output logic [2:0]  o_req_id,
    output logic [31:0] o_vector,
    output logic [7:0]  o_lost_cnt
);

    logic [6:0] r_prev;
    logic [6:0] r_pending;
    logic [6:0] r_in_service;
    logic [7:0] r_lost_cnt;

    logic [6:0] w_rise;
    logic [6:0] w_eligible;
    logic [2:0] w_top;
    logic [2:0] w_cur;
    logic       w_req;
    logic [2:0] w_req_id;
    logic [6:0] w_ack_clr;
    logic [6:0] w_eret_clr;
    logic [6:0] w_lost_bits;
    logic [2:0] w_lost_inc;
    logic [8:0] w_lost_sum;

    assign w_rise     = i_irq_in & ~r_prev;
    assign w_eligible = r_pending & i_mask_in;

    // Descending scans so the lowest set index (highest priority) wins; w_cur = 7 means idle.
    always_comb begin
        w_top = 3'd0;
        w_cur = 3'd7;
        for (int i = 6; i >= 0; i--) begin
            if (w_eligible[i]) w_top = 3'(i);
            if (r_in_service[i]) w_cur = 3'(i);
        end
    end

    assign w_req    = (w_eligible != 7'd0) && (w_top < w_cur);
    assign w_req_id = w_req ? w_top : 3'd0;

    assign w_ack_clr  = (i_irq_ack && w_req) ? (7'd1 << w_req_id) : 7'd0;
    assign w_eret_clr = i_eret ? (r_in_service & (~r_in_service + 7'd1)) : 7'd0;

    // An edge is lost only if its pending bit survives this cycle's acknowledge.
    assign w_lost_bits = w_rise & r_pending & ~w_ack_clr;

    always_comb begin
        w_lost_inc = 3'd0;
        for (int i = 0; i < 7; i++) begin
            w_lost_inc = w_lost_inc + {2'b00, w_lost_bits[i]};
        end
    end

    assign w_lost_sum = {1'b0, r_lost_cnt} + {6'b0, w_lost_inc};

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_prev       <= 7'd0;
            r_pending    <= 7'd0;
            r_in_service <= 7'd0;
            r_lost_cnt   <= 8'd0;
        end else begin
            r_prev       <= i_irq_in;
            r_pending    <= (r_pending & ~w_ack_clr) | w_rise;
            r_in_service <= (r_in_service & ~w_eret_clr) | w_ack_clr;
            r_lost_cnt   <= w_lost_sum[8] ? 8'hFF : w_lost_sum[7:0];
        end
    end

    assign o_pending    = r_pending;
    assign o_in_service = r_in_service;
    assign o_req        = w_req;
    assign o_req_id     = w_req_id;
    assign o_vector     = VEC_BASE + {27'b0, w_req_id, 2'b00};
    assign o_lost_cnt   = r_lost_cnt;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// tb/tb_irq_pending_ctrl.sv - scoreboard bench for irq_pending_ctrl against a per-source reference model
module tb_irq_pending_ctrl;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic [6:0]  i_irq_in = 7'd0;
    logic [6:0]  i_mask_in = 7'h7F;
    logic        i_irq_ack = 1'b0;
    logic        i_eret = 1'b0;
    logic [6:0]  o_pending;
    logic [6:0]  o_in_service;
    logic        o_req;
    logic [2:0]  o_req_id;
    logic [31:0] o_vector;
    logic [7:0]  o_lost_cnt;

    irq_pending_ctrl dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_irq_in     (i_irq_in),
        .i_mask_in    (i_mask_in),
        .i_irq_ack    (i_irq_ack),
        .i_eret       (i_eret),
        .o_pending    (o_pending),
        .o_in_service (o_in_service),
        .o_req        (o_req),
        .o_req_id     (o_req_id),
        .o_vector     (o_vector),
        .o_lost_cnt   (o_lost_cnt)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        logic [6:0]  pend;
        logic [6:0]  isv;
        logic        req;
        logic [2:0]  id;
        logic [31:0] vec;
        logic [7:0]  lost;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: one flag per source, priority by linear search.
    bit m_prev[7];
    bit m_pend[7];
    bit m_isv[7];
    int m_lost;
    logic [6:0] irq_level = 7'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge i_clock) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pending",    {25'd0, o_pending},    {25'd0, e.pend});
            chk("in_service", {25'd0, o_in_service}, {25'd0, e.isv});
            chk("req",        {31'd0, o_req},        {31'd0, e.req});
            chk("req_id",     {29'd0, o_req_id},     {29'd0, e.id});
            chk("vector",     o_vector,              e.vec);
            chk("lost_cnt",   {24'd0, o_lost_cnt},   {24'd0, e.lost});
        end
    end

    task automatic step(input logic [6:0] irq, input logic [6:0] mask,
                        input logic ack, input logic eret, input logic rst);
        exp_t e;
        int top, cur, ack_idx, eret_idx;
        bit rise;
        bit n_pend[7];
        bit n_isv[7];
        i_irq_in  = irq;
        i_mask_in = mask;
        i_irq_ack = ack;
        i_eret    = eret;
        i_reset   = rst;
        irq_level = irq;
        if (rst) begin
            for (int i = 0; i < 7; i++) begin
                m_prev[i] = 0; m_pend[i] = 0; m_isv[i] = 0;
            end
            m_lost = 0;
        end
        top = -1;
        for (int i = 6; i >= 0; i--) if (m_pend[i] && mask[i]) top = i;
        cur = 7;
        for (int i = 6; i >= 0; i--) if (m_isv[i]) cur = i;
        e.req = (top >= 0) && (top < cur);
        e.id  = e.req ? 3'(top) : 3'd0;
        e.vec = 32'h0000_0100 + 32'(e.id) * 4;
        for (int i = 0; i < 7; i++) begin
            e.pend[i] = m_pend[i];
            e.isv[i]  = m_isv[i];
        end
        e.lost = 8'(m_lost);
        q.push_back(e);
        if (!rst) begin
            ack_idx  = (ack && e.req) ? top : -1;
            eret_idx = (eret && cur < 7) ? cur : -1;
            for (int i = 0; i < 7; i++) begin
                rise = irq[i] && !m_prev[i];
                if (rise && m_pend[i] && i != ack_idx) m_lost++;
                n_pend[i] = (m_pend[i] && i != ack_idx) || rise;
                n_isv[i]  = (m_isv[i] && i != eret_idx) || (i == ack_idx);
            end
            if (m_lost > 255) m_lost = 255;
            for (int i = 0; i < 7; i++) begin
                m_pend[i] = n_pend[i];
                m_isv[i]  = n_isv[i];
                m_prev[i] = irq[i];
            end
        end
        @(posedge i_clock);
        #1;
    endtask

    initial begin
        @(posedge i_clock);
        #1;
        step(7'h00, 7'h7F, 0, 0, 1);
        step(7'h00, 7'h7F, 0, 0, 1);
        step(7'h00, 7'h7F, 0, 0, 0);

        // Single interrupt on source 3
        step(7'h08, 7'h7F, 0, 0, 0);
        step(7'h08, 7'h7F, 0, 0, 0);
        step(7'h00, 7'h7F, 1, 0, 0);
        step(7'h00, 7'h7F, 0, 0, 0);
        step(7'h00, 7'h7F, 0, 1, 0);
        step(7'h00, 7'h7F, 0, 0, 0);

        // Priority and preemption
        step(7'h08, 7'h7F, 0, 0, 0);
        step(7'h00, 7'h7F, 1, 0, 0);
        step(7'h20, 7'h7F, 0, 0, 0);
        step(7'h20, 7'h7F, 0, 0, 0);
        step(7'h22, 7'h7F, 0, 0, 0);
        step(7'h22, 7'h7F, 1, 0, 0);
        step(7'h00, 7'h7F, 0, 1, 0);
        step(7'h00, 7'h7F, 0, 1, 0);
        step(7'h00, 7'h7F, 0, 0, 0);
        step(7'h00, 7'h7F, 1, 0, 0);
        step(7'h00, 7'h7F, 0, 1, 0);

        // Masking: capture while masked, request appears with the mask change
        step(7'h02, 7'h7D, 0, 0, 0);
        step(7'h00, 7'h7D, 0, 0, 0);
        step(7'h00, 7'h7F, 1, 0, 0);
        step(7'h00, 7'h7F, 0, 1, 0);

        // Lost edge, then set-wins on a same-cycle ack
        step(7'h04, 7'h7F, 0, 0, 0);
        step(7'h00, 7'h7F, 0, 0, 0);
        step(7'h04, 7'h7F, 0, 0, 0);
        step(7'h00, 7'h7F, 0, 0, 0);
        step(7'h04, 7'h7F, 1, 0, 0);
        step(7'h00, 7'h7F, 0, 1, 0);

        // Saturation: pending bit 2 is held, every toggle is a lost edge
        for (int k = 0; k < 300; k++) begin
            step(7'h04, 7'h00, 0, 0, 0);
            step(7'h00, 7'h00, 0, 0, 0);
        end
        step(7'h00, 7'h7F, 1, 0, 0);
        step(7'h00, 7'h7F, 0, 1, 0);

        // Simultaneous ack and eret
        step(7'h10, 7'h7F, 0, 0, 0);
        step(7'h00, 7'h7F, 1, 0, 0);
        step(7'h01, 7'h7F, 0, 0, 0);
        step(7'h00, 7'h7F, 1, 1, 0);
        step(7'h00, 7'h7F, 0, 1, 0);

        // Asynchronous reset with Pending = 05 and In_Service = 08
        step(7'h08, 7'h7F, 0, 0, 0);
        step(7'h00, 7'h7F, 1, 0, 0);
        step(7'h05, 7'h00, 0, 0, 0);
        step(7'h05, 7'h00, 0, 0, 0);
        step(7'h05, 7'h00, 1, 1, 1);
        step(7'h05, 7'h7F, 0, 0, 0);
        step(7'h05, 7'h7F, 0, 0, 0);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            logic [6:0] irq, mask;
            irq  = irq_level ^ (($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'd0);
            mask = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h7F;
            step(irq, mask, ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 299) == 0));
        end

        @(negedge i_clock);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_pending_ctrl.md
# irq_pending_ctrl

Interrupt pending and priority controller for the single-cycle RISC-V CPU. It captures rising edges on seven external interrupt lines and holds them as pending bits. It applies an enable mask and tracks nested in-service levels. It produces one prioritised request with its ID and handler vector. The block feeds the CPU's seven-way interrupt-request OR and the PC-select logic, and consumes the CPU's acknowledge and return (ERET) strobes.

## Interface
- VEC_BASE, 32'h0000_0100, handler vector base; Vector = VEC_BASE + (Req_Id << 2)
- Clock  in  1  system clock, all state updates on rising edge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- IRQ_In  in  7  interrupt source levels, synchronous to Clock; bit 0 = highest priority
- Mask_In  in  7  per-source enable, 1 = enabled
- IRQ_Ack  in  1  CPU enters handler this cycle (one-cycle strobe)
- Eret  in  1  CPU returns from handler this cycle (one-cycle strobe)
- Pending  out  7  registered pending bits
- In_Service  out  7  registered in-service bits
- Req  out  1  interrupt request to CPU
- Req_Id  out  3  index of requested source, 0..6
- Vector  out  32  handler address for Req_Id
- Lost_Cnt  out  8  saturating count of edges dropped because the source's pending bit was already set

## Operation
- Edge detect: the Prev register holds IRQ_In from the previous edge. At each edge, Rise = IRQ_In & ~Prev.
- Pending update: Pending <= (Pending & ~AckClr) | Rise. A new rise on a source being acknowledged in the same cycle re-sets its bit, so set wins.
- Mask gates only the request, never capture. Masked sources still accumulate Pending.
- Eligible = Pending & Mask_In. Top = lowest set index of Eligible. Cur = lowest set index of In_Service, or 7 if none.
- Req = 1 iff Eligible ≠ 0 and Top < Cur. Lower-index sources preempt an active handler; equal or lower priority waits.
- Req_Id = Top when Req = 1, else 3'd0. Vector = VEC_BASE + {27'b0, Req_Id, 2'b00}. Req, Req_Id and Vector are combinational from registers and Mask_In only.
- IRQ_Ack with Req = 1: clear Pending[Req_Id] and set In_Service[Req_Id]. IRQ_Ack with Req = 0 is ignored.
- Eret: clear the lowest set bit of In_Service. Eret with In_Service = 0 is a no-op.
- IRQ_Ack and Eret in the same cycle:
  - Both are evaluated against pre-edge state and both are applied.
  - The bit cleared (Cur) and the bit set (Top < Cur) are always distinct.
- Lost_Cnt increments by the number of sources with Rise & Pending, excluding any source cleared by Ack that same cycle. It saturates at 8'hFF.

## Timing
- Reset values, asserted asynchronously: Prev = 0, Pending = 0, In_Service = 0, Lost_Cnt = 0. Hence Req = 0, Req_Id = 0, Vector = VEC_BASE.
- Reset asserted mid-operation aborts everything, including a same-cycle Ack or Eret. Outputs reach reset values without waiting for a clock edge.
- First edge after Reset deasserts: Prev = 0. Any IRQ_In line already high counts as a rise and becomes pending.
- Latency, IRQ_In rise to Req:
  - IRQ_In goes high before edge N; Pending and Req are high after edge N.
  - One edge of latency, with no combinational path from IRQ_In to Req.
- Latency, Ack to state change: Pending, In_Service and Req all update after the same edge that samples IRQ_In.
- Mask_In change affects Req in the same cycle.
- A level held high produces exactly one rise. Re-triggering requires IRQ_In to be low for at least one sampled edge.
- Nesting depth is bounded at 7 by In_Service width. No overflow state exists.

## Test plan
- Reset behaviour:
  - Stimulus: assert Reset mid-cycle while Pending = 7'h05 and In_Service = 7'h08.
  - Required: all of Pending, In_Service, Lost_Cnt and Req are 0 before the next clock edge.
  - Required: Vector = 32'h0000_0100.
- Single interrupt:
  - Stimulus: Mask_In = 7'h7F, IRQ_In[3] rises.
  - Required after one edge: Req = 1, Req_Id = 3, Vector = 32'h0000_010C.
  - Stimulus: IRQ_Ack pulse. Required: Pending = 0, In_Service = 7'h08, Req = 0.
  - Stimulus: Eret pulse. Required: In_Service = 0.
- Priority and preemption:
  - Stimulus: In_Service = 7'h08; IRQ_In[5] rises. Required: Req = 0.
  - Stimulus: IRQ_In[1] rises. Required: Req = 1, Req_Id = 1.
  - Stimulus: Ack. Required: In_Service = 7'h0A.
  - Stimulus: Eret. Required: In_Service = 7'h08.
  - Stimulus: Eret. Required: In_Service = 0, then Req = 1 with Req_Id = 5.
- Masking:
  - Stimulus: Mask_In = 7'h7D, IRQ_In[1] rises. Required: Pending = 7'h02, Req = 0.
  - Stimulus: set Mask_In = 7'h7F. Required: Req = 1, Req_Id = 1 in the same cycle.
- Lost edges and set-wins:
  - Stimulus: pulse IRQ_In[2] high, low, high with no Ack. Required: Lost_Cnt = 1.
  - Stimulus: a rise on bit 2 in the same cycle as Ack of bit 2. Required: Pending[2] stays 1, Lost_Cnt unchanged.
  - Stimulus: 300 lost edges. Required: Lost_Cnt = 8'hFF.
- Simultaneous Ack and Eret:
  - Stimulus: In_Service = 7'h10 and Pending = 7'h01; assert IRQ_Ack and Eret together.
  - Required: In_Service = 7'h01, Pending = 0.
